// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: operand/result valid-ready handshake bundle for the shift-add multiplier.
interface shift_add_multiplier_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] w;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] product;
  logic overflow;
  modport master (output in_valid, x, w, out_ready, input in_ready, out_valid, product, overflow);
  modport slave (input in_valid, x, w, out_ready, output in_ready, out_valid, product, overflow);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Define SHIFT_ADD_MULT_SAT_EN to saturate product to all ones on overflow instead of wrapping.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  shift_add_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, next;
  logic [2*WIDTH-1:0] acc, mcand, acc_next;
  logic [WIDTH-1:0] mplr, product;
  logic [CW-1:0] cnt;
  logic overflow, last;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.product = product;
  assign bus.overflow = overflow;
  always_comb begin
    acc_next = mplr[0] ? acc + mcand : acc;
    last = cnt == CW'(WIDTH - 1);
    next = state;
    if (state == IDLE && bus.in_valid) next = BUSY;
    if (state == BUSY && last) next = DONE;
    if (state == DONE && bus.out_ready) next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
      product <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && bus.in_valid) begin
        mcand <= {{WIDTH{1'b0}}, bus.x};
        mplr <= bus.w;
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= acc_next;
        mcand <= mcand << 1;
        mplr <= mplr >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          overflow <= |acc_next[2*WIDTH-1:WIDTH];
`ifdef SHIFT_ADD_MULT_SAT_EN
          product <= |acc_next[2*WIDTH-1:WIDTH] ? '1 : acc_next[WIDTH-1:0];
`else
          product <= acc_next[WIDTH-1:0];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard bench with random operands, backpressure, input noise and mid-op reset.
module tb_shift_add_multiplier;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  shift_add_multiplier_if #(.WIDTH(W)) bus ();
  shift_add_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [W-1:0] p; logic o; int t;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, hold_cnt = 0;
  logic prev_ov = 1'b0, prev_hs = 1'b0, held_o;
  logic [W-1:0] held_p;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(int a, int b, int t);
    exp_t e;
    int full;
    full = a * b;
    e.o = (full >> W) != 0;
`ifdef SHIFT_ADD_MULT_SAT_EN
    e.p = e.o ? {W{1'b1}} : full[W-1:0];
`else
    e.p = full[W-1:0];
`endif
    e.t = t;
    return e;
  endfunction
  // out_ready changes just after the rising edge so it is stable at the sampling negedge
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) hold_cnt--;
      end else bus.out_ready = ($urandom % 3) != 0;
    end
  end
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("in_ready_after_hs", 32'(bus.in_ready), 1);
        chk("out_valid_after_hs", 32'(bus.out_valid), 0);
      end
      if (bus.out_valid && !prev_ov) begin
        if (q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("product", 32'(bus.product), 32'(e.p));
          chk("overflow", 32'(bus.overflow), 32'(e.o));
          chk("latency", cyc - e.t, W);
        end
        held_p = bus.product;
        held_o = bus.overflow;
      end else if (bus.out_valid) begin
        chk("product_stable", 32'(bus.product), 32'(held_p));
        chk("overflow_stable", 32'(bus.overflow), 32'(held_o));
      end
      if (bus.out_valid) chk("in_ready_in_done", 32'(bus.in_ready), 0);
      prev_ov = bus.out_valid;
      prev_hs = bus.out_valid && bus.out_ready;
    end
  end
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
  endtask
  task automatic issue(int a, int b, bit noise);
    int n = 0;
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x = W'(a);
    bus.w = W'(b);
    q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_drop", 32'(bus.in_ready), 0);
    if (noise) begin
      while (!bus.in_ready && n < 200) begin
        bus.in_valid = 1'($urandom % 2);
        bus.x = W'($urandom);
        bus.w = W'($urandom);
        @(negedge clk);
        n++;
      end
      bus.in_valid = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.w = '0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_product", 32'(bus.product), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(3, 5, 0);
    issue(20, 13, 0);
    issue(255, 255, 0);
    issue(0, 200, 0);
    hold_cnt = 5;
    issue(7, 11, 1);
    issue(255, 1, 1);
    issue(16, 16, 0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom % 5 == 0) hold_cnt = $urandom_range(1, 6);
      issue($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom % 2));
    end
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.x = 8'd200;
    bus.w = 8'd100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_product", 32'(bus.product), 0);
    chk("midrst_overflow", 32'(bus.overflow), 0);
    repeat (12) begin
      @(negedge clk);
      chk("rst_hold_out_valid", 32'(bus.out_valid), 0);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("aborted_no_result", 32'(bus.out_valid), 0);
    end
    issue(7, 9, 0);
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_after_rst", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
